// File: rtl/uart_rx_param_if.sv
// Receiver-side bus: serial input, FIFO head word with flags, pop handshake and status.
interface uart_rx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) ();
  logic                          rx;
  logic [DATA_BITS-1:0]          data_out;
  logic                          parity_err;
  logic                          frame_err;
  logic                          data_valid;
  logic                          data_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun;
  logic                          clear_overrun;
  logic                          receiving;

  modport master (
    input  rx, data_ready, clear_overrun,
    output data_out, parity_err, frame_err, data_valid, fifo_count, overrun, receiving
  );

  modport slave (
    output rx, data_ready, clear_overrun,
    input  data_out, parity_err, frame_err, data_valid, fifo_count, overrun, receiving
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled framing FSM, small output FIFO.
// Word visible 1 clock after the final stop sample; a full FIFO drops the word and sets sticky overrun.
module uart_rx_param #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clock,
  input logic             reset_n,
  uart_rx_param_if.master bus
);
  localparam int DIV_RAW = CLK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = DATA_BITS + 2;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_sync;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err;
  logic                 active, tick, sample, push;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 pop, push_ok, overrun_q;
  logic [EW-1:0]        word_in, head;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  assign active = (state == S_START) || (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
  assign tick   = active && (div_cnt == DIV_LAST);
  assign sample = tick && (samp_cnt == ((state == S_START) ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      S_IDLE:      if (!rx_sync) state_next = S_START;
      S_START:     if (sample) state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:      if (sample && bit_cnt == DATA_LAST) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (sample) state_next = S_STOP;
      S_STOP: begin
        if (sample && bit_cnt == STOP_LAST) begin
          push       = 1'b1;
          // A low final stop sample may be the start of a break; wait it out.
          state_next = rx_sync ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (rx_sync) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else if (!active) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) samp_cnt <= sample ? '0 : samp_cnt + SW'(1);
      if (sample) begin
        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 4'd1;
        case (state)
          S_START: begin
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
          S_DATA:   shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
          S_PARITY: par_err <= ((^shreg) ^ rx_sync) != (PARITY == 1);
          S_STOP:   if (!rx_sync) frm_err <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // The final stop sample lands in the pushed word the same cycle it is taken.
  assign word_in = {shreg, par_err, frm_err | ~rx_sync};
  assign pop     = (count != '0) && bus.data_ready;
  assign push_ok = push && ((count < DEPTH) || pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= word_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && !push_ok)   overrun_q <= 1'b1;
      else if (bus.clear_overrun) overrun_q <= 1'b0;
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.data_out   = head[EW-1:2];
  assign bus.parity_err = head[1];
  assign bus.frame_err  = head[0];
  assign bus.data_valid = (count != '0);
  assign bus.fifo_count = count;
  assign bus.overrun    = overrun_q;
  assign bus.receiving  = active;
endmodule
